// File: rtl/riscv_pkg.sv
// Shared fetch-side types and defaults: next-PC select encoding, fetch FSM
// state encoding, and the reset and trap vector defaults.
package riscv_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        FS_REQ  = 2'b00,
        FS_WAIT = 2'b01,
        FS_HOLD = 2'b10
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

endpackage

// File: rtl/adder32.sv
// Plain 32-bit adder shared by the datapath. The carry out is dropped, so
// the sum wraps modulo 2^32.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_reg.sv
// 32-bit program counter register with asynchronous reset to a fixed vector
// and a load enable.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Hold the PC; reload only when the fetch unit retires an instruction.
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch / PC unit. One request outstanding at a time:
// REQ issues the address, WAIT takes the response, HOLD presents the
// instruction until decode retires it, at which point the next PC is loaded.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned BRANCH/JALR targets
// redirect to TRAP_VECTOR and raise a one-cycle trap pulse). Without it,
// target bits [1:0] are cleared and the trap outputs are tied low.
module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap,
    output logic [31:0] trap_addr
);

    fetch_state_t state;
    fetch_state_t state_next;
    pc_src_t      src;
    logic         retire;
    logic         target_sel;
    logic [31:0]  target;
    logic [31:0]  pc_next;

    assign src    = pc_src_t'(pc_src);
    assign retire = (state == FS_HOLD) && instr_ready;

    assign imem_req_valid = (state == FS_REQ);
    assign imem_addr      = pc;
    assign instr_valid    = (state == FS_HOLD);

    adder32 u_pc_inc (
        .a   (pc),
        .b   (32'd4),
        .sum (pc_plus4)
    );

    pc_reg #(
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .load  (retire),
        .d     (pc_next),
        .q     (pc)
    );

    // Fetch FSM next-state: responses only matter while waiting for one.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            FS_REQ:  if (imem_req_ready) state_next = FS_WAIT;
            FS_WAIT: if (imem_rsp_valid) state_next = FS_HOLD;
            FS_HOLD: if (instr_ready)    state_next = FS_REQ;
            default: state_next = FS_REQ;
        endcase
    end

    // Fetch FSM state register; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FS_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Capture the instruction word when the response arrives in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= 32'h0000_0000;
        end else if ((state == FS_WAIT) && imem_rsp_valid) begin
            instr <= imem_rsp_data;
        end
    end

    // Select the redirect target; JALR clears bit 0 before any alignment check.
    always_comb begin
        target     = branch_target;
        target_sel = 1'b0;
        case (src)
            PC_BRANCH: begin
                target     = branch_target;
                target_sel = 1'b1;
            end
            PC_JALR: begin
                target     = jalr_target & 32'hFFFF_FFFE;
                target_sel = 1'b1;
            end
            default: begin
                target     = branch_target;
                target_sel = 1'b0;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;

    assign misaligned = target_sel && (target[1:0] != 2'b00);

    // Next PC: sequential, aligned redirect, or the trap vector.
    always_comb begin
        pc_next = pc_plus4;
        if (misaligned) begin
            pc_next = TRAP_VECTOR;
        end else if (target_sel) begin
            pc_next = target;
        end
    end

    // One-cycle trap pulse; trap_addr keeps the last offending target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap      <= 1'b0;
            trap_addr <= 32'h0000_0000;
        end else begin
            trap <= retire && misaligned;
            if (retire && misaligned) begin
                trap_addr <= target;
            end
        end
    end
`else
    // Next PC: sequential, or the redirect target forced to word alignment.
    always_comb begin
        pc_next = pc_plus4;
        if (target_sel) begin
            pc_next = target & 32'hFFFF_FFFC;
        end
    end

    assign trap      = 1'b0;
    assign trap_addr = 32'h0000_0000;
`endif

endmodule
